wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 172 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// -----------------------------------------------------------------------------
// wb_arbiter -- writeback-stage arbiter in front of the register file's single
// write port. Each cycle it picks one result from the single-cycle ALU, a
// one-entry load buffer or a mul/div result FIFO. The chosen result is written
// through a registered write port.
//
// Priority, highest first: ALU (rd != 0), starved mul/div head, load buffer,
// mul/div head. Writes to r0 are dropped at the source handshake.
//
// Optional feature macro: WB_PENDING_EN
//   Adds query_reg / pending_hit. pending_hit flags a register that still has
//   a buffered, not-yet-written result.
//
// Ports:
//   clk                          rising-edge clock
//   reset                        asynchronous, active-low reset
//   alu_valid/alu_rd/alu_data    ALU result (no backpressure)
//   ld_valid/ld_ready/ld_rd/ld_data   load result, ready/valid handshake
//   md_valid/md_ready/md_rd/md_data   mul/div result, ready/valid handshake
//   query_reg, pending_hit       (WB_PENDING_EN only) pending-write lookup
//   reg_write/write_reg/write_data    registered register-file write port
// -----------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int REGADDR_WIDTH = 4,
  parameter int MD_DEPTH      = 4,
  parameter int STARVE_LIMIT  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alu_valid,
  input  logic [REGADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [REGADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0]    ld_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [REGADDR_WIDTH-1:0] md_rd,
  input  logic [DATA_WIDTH-1:0]    md_data,
`ifdef WB_PENDING_EN
  input  logic [REGADDR_WIDTH-1:0] query_reg,
  output logic                     pending_hit,
`endif
  output logic                     reg_write,
  output logic [REGADDR_WIDTH-1:0] write_reg,
  output logic [DATA_WIDTH-1:0]    write_data
);

  localparam int PTR_W = $clog2(MD_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    if (a >= AGE_W'(STARVE_LIMIT)) return AGE_W'(STARVE_LIMIT);
    else                           return a + AGE_W'(1);
  endfunction

  // Load buffer
  logic                     ld_buf_vld;
  logic [REGADDR_WIDTH-1:0] ld_buf_rd;
  logic [DATA_WIDTH-1:0]    ld_buf_data;

  // Mul/div FIFO
  logic [REGADDR_WIDTH-1:0] md_rd_mem   [MD_DEPTH];
  logic [DATA_WIDTH-1:0]    md_data_mem [MD_DEPTH];
  logic [PTR_W-1:0]         md_wr_ptr;
  logic [PTR_W-1:0]         md_rd_ptr;
  logic [CNT_W-1:0]         md_count;
  logic [AGE_W-1:0]         md_age;

  logic md_head_vld, md_promo;
  logic sel_alu, sel_ld, sel_md;
  logic ld_store, md_push, md_pop;

  logic                     wr_vld_p0;
  logic [REGADDR_WIDTH-1:0] wr_rd_p0;
  logic [DATA_WIDTH-1:0]    wr_data_p0;

  // Stage p0: source selection
  always_comb begin
    md_head_vld = (md_count != '0);
    md_promo    = md_head_vld && (md_age >= AGE_W'(STARVE_LIMIT));
    sel_alu     = alu_valid && (alu_rd != '0);
    // A promoted mul/div head outranks the load buffer but never the ALU.
    sel_md      = !sel_alu && (md_promo || (!ld_buf_vld && md_head_vld));
    sel_ld      = !sel_alu && !md_promo && ld_buf_vld;

    // Same-cycle drain and refill of the load buffer.
    ld_ready = !ld_buf_vld || sel_ld;
    // No pass-through credit when the FIFO is full.
    md_ready = (md_count < CNT_W'(MD_DEPTH));

    // r0 results complete the handshake but are never stored.
    ld_store = ld_valid && ld_ready && (ld_rd != '0);
    md_push  = md_valid && md_ready && (md_rd != '0);
    md_pop   = sel_md;

    wr_vld_p0  = 1'b0;
    wr_rd_p0   = alu_rd;
    wr_data_p0 = alu_data;
    if (sel_alu) begin
      wr_vld_p0 = 1'b1;
    end else if (sel_ld) begin
      wr_vld_p0  = 1'b1;
      wr_rd_p0   = ld_buf_rd;
      wr_data_p0 = ld_buf_data;
    end else if (sel_md) begin
      wr_vld_p0  = 1'b1;
      wr_rd_p0   = md_rd_mem[md_rd_ptr];
      wr_data_p0 = md_data_mem[md_rd_ptr];
    end
  end

  // Stage p1: control state and registered write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ld_buf_vld <= 1'b0;
      md_wr_ptr  <= '0;
      md_rd_ptr  <= '0;
      md_count   <= '0;
      md_age     <= '0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      if (ld_store)    ld_buf_vld <= 1'b1;
      else if (sel_ld) ld_buf_vld <= 1'b0;

      if (md_push) md_wr_ptr <= md_wr_ptr + PTR_W'(1);
      if (md_pop)  md_rd_ptr <= md_rd_ptr + PTR_W'(1);
      if (md_push && !md_pop)      md_count <= md_count + CNT_W'(1);
      else if (md_pop && !md_push) md_count <= md_count - CNT_W'(1);

      if (md_pop)           md_age <= '0;
      else if (md_head_vld) md_age <= age_sat_inc(md_age);

      reg_write <= wr_vld_p0;
      if (wr_vld_p0) begin
        write_reg  <= wr_rd_p0;
        write_data <= wr_data_p0;
      end
    end
  end

  // Buffered payloads carry no reset; their valid state lives above.
  always_ff @(posedge clk) begin
    if (ld_store) begin
      ld_buf_rd   <= ld_rd;
      ld_buf_data <= ld_data;
    end
    if (md_push) begin
      md_rd_mem[md_wr_ptr]   <= md_rd;
      md_data_mem[md_wr_ptr] <= md_data;
    end
  end

`ifdef WB_PENDING_EN
  logic pend_md;
  always_comb begin
    pend_md = 1'b0;
    for (int i = 0; i < MD_DEPTH; i++) begin
      if ((CNT_W'(i) < md_count) && (md_rd_mem[md_rd_ptr + PTR_W'(i)] == query_reg))
        pend_md = 1'b1;
    end
    pending_hit = (query_reg != '0) &&
                  ((ld_buf_vld && (ld_buf_rd == query_reg)) || pend_md);
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid, md_valid;
  logic [AW-1:0] alu_rd, ld_rd, md_rd;
  logic [DW-1:0] alu_data, ld_data, md_data;
  logic          ld_ready, md_ready;
  logic          reg_write;
  logic [AW-1:0] write_reg;
  logic [DW-1:0] write_data;
`ifdef WB_PENDING_EN
  logic [AW-1:0] query_reg = '0;
  logic          pending_hit;
`endif

  int tests = 0;
  int fails = 0;
  logic [AW+DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_WIDTH(DW), .REGADDR_WIDTH(AW), .MD_DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
`ifdef WB_PENDING_EN
    .query_reg(query_reg), .pending_hit(pending_hit),
`endif
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    assert (act === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void exp_push(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    exp_q.push_back({rd, d});
  endfunction

  // Advance one clock, sample 1 time unit after the edge and score any write.
  task automatic tick();
    logic [AW+DW-1:0] e;
    @(posedge clk);
    #1;
    if (reg_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {28'd0, write_reg}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("write_reg", {28'd0, write_reg}, {28'd0, e[AW+DW-1:DW]});
        chk("write_data", {16'd0, write_data}, {16'd0, e[DW-1:0]});
      end
    end
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    ld_valid  = 0; ld_rd  = '0; ld_data  = '0;
    md_valid  = 0; md_rd  = '0; md_data  = '0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_reg_write", {31'd0, reg_write}, 32'd0);
    chk("rst_write_reg", {28'd0, write_reg}, 32'd0);
    chk("rst_write_data", {16'd0, write_data}, 32'd0);
    reset = 1'b1;
    #1;
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd1);

    // 1: single ALU write, one-cycle latency
    alu_valid = 1; alu_rd = 4'd3; alu_data = 16'h1234;
    exp_push(4'd3, 16'h1234);
    tick();
    chk("t1_we", {31'd0, reg_write}, 32'd1);
    alu_valid = 0;
    tick();
    chk("t1_idle", {31'd0, reg_write}, 32'd0);
    chk("t1_hold_reg", {28'd0, write_reg}, 32'd3);

    // 2: ALU and load together; load drains next cycle while a new load refills
    alu_valid = 1; alu_rd = 4'd2; alu_data = 16'h0011;
    ld_valid = 1; ld_rd = 4'd5; ld_data = 16'hBEEF;
    exp_push(4'd2, 16'h0011);
    exp_push(4'd5, 16'hBEEF);
    exp_push(4'd6, 16'h0606);
    #1 chk("t2_ld_ready0", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("t2_alu_we", {31'd0, reg_write}, 32'd1);
    alu_valid = 0;
    ld_rd = 4'd6; ld_data = 16'h0606;
    #1 chk("t2_ld_ready1", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("t2_ld_we", {31'd0, reg_write}, 32'd1);
    ld_valid = 0;
    tick();
    chk("t2_ld2_we", {31'd0, reg_write}, 32'd1);
    tick();
    chk("t2_idle", {31'd0, reg_write}, 32'd0);

    // 3: ALU busy 8 cycles, 5 MD results offered, FIFO fills at 4
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1; alu_rd = AW'(8 + i); alu_data = DW'(16'hA000 + i);
      exp_push(AW'(8 + i), DW'(16'hA000 + i));
      if (i < 5) begin
        md_valid = 1; md_rd = AW'(i + 1); md_data = DW'(16'hD000 + i);
        #1;
        chk($sformatf("t3_md_ready%0d", i), {31'd0, md_ready}, (i < 4) ? 32'd1 : 32'd0);
        if (i == 4) md_valid = 0;
      end else begin
        md_valid = 0;
      end
      tick();
      chk("t3_alu_we", {31'd0, reg_write}, 32'd1);
    end
    alu_valid = 0;
    for (int i = 0; i < 4; i++) exp_push(AW'(i + 1), DW'(16'hD000 + i));
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_md_we", {31'd0, reg_write}, 32'd1);
    end
    tick();
    chk("t3_idle", {31'd0, reg_write}, 32'd0);
    chk("t3_q_empty", exp_q.size(), 32'd0);

    // 4: loads every cycle vs one MD result: 3 load wins, then MD promoted
    ld_valid = 1; ld_rd = 4'd10; ld_data = 16'h1000;
    exp_push(4'd10, 16'h1000);
    tick();
    ld_rd = 4'd11; ld_data = 16'h1001;
    md_valid = 1; md_rd = 4'd7; md_data = 16'h7777;
    exp_push(4'd11, 16'h1001);
    exp_push(4'd12, 16'h1002);
    exp_push(4'd13, 16'h1003);
    exp_push(4'd7, 16'h7777);
    exp_push(4'd14, 16'h1004);
    tick();
    md_valid = 0;
    for (int i = 2; i <= 4; i++) begin
      ld_rd = AW'(10 + i); ld_data = DW'(16'h1000 + i);
      #1 chk("t4_ld_ready", {31'd0, ld_ready}, 32'd1);
      tick();
    end
    ld_rd = 4'd15; ld_data = 16'h1005;
    #1 chk("t4_ld_ready_promo", {31'd0, ld_ready}, 32'd0);
    ld_valid = 0;
    tick();
    chk("t4_md_we", {31'd0, reg_write}, 32'd1);
    tick();
    tick();
    chk("t4_idle", {31'd0, reg_write}, 32'd0);
    chk("t4_q_empty", exp_q.size(), 32'd0);

    // 5: r0 destinations complete handshakes but never write
    alu_valid = 1; alu_rd = '0; alu_data = 16'hFFFF;
    ld_valid = 1; ld_rd = '0; ld_data = 16'hEEEE;
    md_valid = 1; md_rd = '0; md_data = 16'hDDDD;
    #1;
    chk("t5_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("t5_md_ready", {31'd0, md_ready}, 32'd1);
    tick();
    chk("t5_we0", {31'd0, reg_write}, 32'd0);
    idle_inputs();
    tick();
    chk("t5_we1", {31'd0, reg_write}, 32'd0);
    chk("t5_ld_ready_after", {31'd0, ld_ready}, 32'd1);
    chk("t5_md_ready_after", {31'd0, md_ready}, 32'd1);

    // 6: reset with FIFO holding 3 entries and load buffer full
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 4'd1; alu_data = DW'(16'h0100 + i);
      exp_push(4'd1, DW'(16'h0100 + i));
      md_valid = 1; md_rd = AW'(9 + i); md_data = DW'(16'h0900 + i);
      ld_valid = (i == 0); ld_rd = 4'd4; ld_data = 16'h0444;
      tick();
    end
    md_valid = 0; ld_valid = 0;
    alu_data = 16'h0103;
    chk("t6_pre_we", {31'd0, reg_write}, 32'd1);
    chk("t6_pre_md_ready", {31'd0, md_ready}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_we", {31'd0, reg_write}, 32'd0);
    chk("t6_rst_reg", {28'd0, write_reg}, 32'd0);
    chk("t6_rst_data", {16'd0, write_data}, 32'd0);
    idle_inputs();
    tick();
    reset = 1'b1;
    #1;
    chk("t6_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("t6_md_ready", {31'd0, md_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t6_no_stale", {31'd0, reg_write}, 32'd0);
    end
    chk("final_q_empty", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
